// File: rtl/inst_cache_pkg.sv
// rtl/inst_cache_pkg.sv - shared constants and state encoding for the instruction cache
package inst_cache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      MISS = 1'b1
   } icache_state_t;

   localparam int DEFAULT_INDEX_BITS = 4;
   localparam int WORD_BITS          = 32;

endpackage

// File: rtl/inst_cache_array.sv
// rtl/inst_cache_array.sv - direct-mapped tag/data/valid storage, combinational read
module inst_cache_array
   import inst_cache_pkg::*;
#(
   parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
   parameter int TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [WORD_BITS-1:0]  rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [WORD_BITS-1:0]  wr_data
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]     valid;
   logic [TAG_BITS-1:0]  tags [LINES];
   logic [WORD_BITS-1:0] data [LINES];

   // Only the valid bits are cleared; stale tag/data are masked by them.
   always_ff @(posedge clk) begin
      if (clear) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_index] <= wr_tag;
         data[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_data  = data[rd_index];

endmodule

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - blocking direct-mapped instruction cache with single-word refill
module inst_cache
   import inst_cache_pkg::*;
#(
   parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 rob_clear,
   input  logic                 fetch_valid,
   input  logic [WORD_BITS-1:0] fetch_pc,
   output logic                 fetch_ready,
   output logic [WORD_BITS-1:0] fetch_inst,
   output logic                 mem_valid,
   output logic [WORD_BITS-1:0] mem_addr,
   input  logic                 mem_ready,
   input  logic [WORD_BITS-1:0] mem_result
);

   localparam int TAG_BITS = 30 - INDEX_BITS;

   icache_state_t state, next_state;
   logic [WORD_BITS-1:0]  miss_addr;
   logic [INDEX_BITS-1:0] fetch_index, fill_index;
   logic [TAG_BITS-1:0]   fetch_tag, fill_tag, line_tag;
   logic                  line_valid;
   logic [WORD_BITS-1:0]  line_data;
   logic                  hit, fill;

   assign fetch_index = fetch_pc[INDEX_BITS+1:2];
   assign fetch_tag   = fetch_pc[WORD_BITS-1:INDEX_BITS+2];
   assign fill_index  = miss_addr[INDEX_BITS+1:2];
   assign fill_tag    = miss_addr[WORD_BITS-1:INDEX_BITS+2];

   // Outputs are gated by rst_in so they read zero while reset is held.
   assign hit  = rst_in && (state == IDLE) && fetch_valid && line_valid && (line_tag == fetch_tag);
   assign fill = rst_in && !rob_clear && rdy_in && (state == MISS) && mem_ready;

   inst_cache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_array (
      .clk      (clk_in),
      .clear    (!rst_in),
      .rd_index (fetch_index),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .wr_en    (fill),
      .wr_index (fill_index),
      .wr_tag   (fill_tag),
      .wr_data  (mem_result)
   );

   always_comb begin
      next_state  = state;
      fetch_ready = 1'b0;
      fetch_inst  = '0;
      mem_valid   = 1'b0;
      case (state)
         IDLE: begin
            if (hit) begin
               fetch_ready = 1'b1;
               fetch_inst  = line_data;
            end else if (fetch_valid) begin
               next_state = MISS;
            end
         end
         MISS: begin
            mem_valid = rst_in;
            if (mem_ready) begin
               next_state = IDLE;
            end
         end
      endcase
      // A flush beats a stall; a stall freezes the state machine.
      if (rob_clear) begin
         next_state = IDLE;
      end else if (!rdy_in) begin
         next_state = state;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state     <= IDLE;
         miss_addr <= '0;
      end else begin
         state <= next_state;
         if ((state == IDLE) && (next_state == MISS)) begin
            miss_addr <= fetch_pc & ~32'h3;
         end
      end
   end

   assign mem_addr = miss_addr;

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - randomized scoreboard bench for inst_cache
module tb_inst_cache;

   localparam int LINES = 16;

   logic        clk = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic        rob_clear = 1'b0;
   logic        fetch_valid = 1'b0;
   logic [31:0] fetch_pc = '0;
   logic        fetch_ready;
   logic [31:0] fetch_inst;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_result = '0;

   int n_pass = 0;
   int n_total = 0;

   logic [31:0] exp_q[$];
   logic [31:0] mem_q[$];

   bit          mdl_valid [LINES];
   logic [31:0] mdl_addr  [LINES];

   int lat  = 1;
   int mode = 0;

   inst_cache dut (
      .clk_in      (clk),
      .rst_in      (rst_in),
      .rdy_in      (rdy_in),
      .rob_clear   (rob_clear),
      .fetch_valid (fetch_valid),
      .fetch_pc    (fetch_pc),
      .fetch_ready (fetch_ready),
      .fetch_inst  (fetch_inst),
      .mem_valid   (mem_valid),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready),
      .mem_result  (mem_result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] img(input logic [31:0] a);
      if (a == 32'h0000_0104) return 32'h00A0_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   // Memory model: answers after lat counted cycles; mode 1 flushes and mode 2 stalls on that answer.
   initial begin
      int cnt = 0;
      int stall_left = 0;
      forever begin
         @(negedge clk);
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) rdy_in = 1'b1;
         end
         if (!rst_in) begin
            cnt = 0;
         end else if (mem_ready) begin
            mem_ready = 1'b0;
            rob_clear = 1'b0;
         end else if (mem_valid && rdy_in) begin
            cnt++;
            if (cnt == lat) begin
               cnt        = 0;
               mem_ready  = 1'b1;
               mem_result = img(mem_addr);
               if (mode == 1) rob_clear = 1'b1;
               if (mode == 2) begin
                  rdy_in     = 1'b0;
                  stall_left = 3;
                  mem_result = ~img(mem_addr);
               end
               mode = 0;
            end
         end else if (!mem_valid) begin
            cnt = 0;
         end
      end
   end

   // Scoreboard monitor.
   initial begin
      bit          prev_mv = 1'b0;
      logic [31:0] cur = '0;
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!rst_in) begin
            prev_mv = 1'b0;
         end else begin
            if (fetch_ready) begin
               chk(!mem_valid, "ready_in_miss", {31'b0, mem_valid}, 32'h0);
               if (exp_q.size() == 0) begin
                  chk(1'b0, "unexpected_ready", fetch_inst, 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  chk(fetch_inst == e, "fetch_inst", fetch_inst, e);
               end
            end else begin
               chk(fetch_inst == 32'h0, "inst_zero_when_idle", fetch_inst, 32'h0);
            end
            if (mem_valid) begin
               if (!prev_mv) begin
                  if (mem_q.size() == 0) begin
                     chk(1'b0, "unexpected_mem_req", mem_addr, 32'h0);
                     cur = mem_addr;
                  end else begin
                     cur = mem_q.pop_front();
                  end
               end
               chk(mem_addr == cur, "mem_addr", mem_addr, cur);
            end
            prev_mv = mem_valid;
         end
      end
   end

   task automatic do_fetch(input logic [31:0] pc, input int latency, input int m);
      int          idx;
      logic [31:0] wa;
      int          exp_lat;
      int          cyc;
      bit          got;
      wa  = pc & ~32'h3;
      idx = int'((wa >> 2) % LINES);
      exp_q.push_back(img(wa));
      if (mdl_valid[idx] && mdl_addr[idx] == wa) begin
         exp_lat = 0;
      end else begin
         lat  = latency;
         mode = m;
         mem_q.push_back(wa);
         if (m == 1) begin
            mem_q.push_back(wa);
            exp_lat = 2 * latency + 2;
         end else if (m == 2) begin
            exp_lat = 2 * latency + 3;
         end else begin
            exp_lat = latency + 1;
         end
         mdl_valid[idx] = 1'b1;
         mdl_addr[idx]  = wa;
      end
      fetch_valid = 1'b1;
      fetch_pc    = pc;
      cyc = 0;
      got = 1'b0;
      while (cyc < 200) begin
         @(negedge clk);
         if (fetch_ready) begin
            got = 1'b1;
            break;
         end
         cyc++;
      end
      chk(got, "fetch_timeout", pc, 32'h0);
      if (got) chk(cyc == exp_lat, "fetch_latency", cyc, exp_lat);
      @(posedge clk);
      #1;
      fetch_valid = 1'b0;
      fetch_pc    = $urandom;
   endtask

   task automatic reset_pulse(input int cycles);
      rst_in = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         chk(!mem_valid, "rst_mem_valid", {31'b0, mem_valid}, 32'h0);
         chk(!fetch_ready, "rst_fetch_ready", {31'b0, fetch_ready}, 32'h0);
         chk(fetch_inst == 32'h0, "rst_fetch_inst", fetch_inst, 32'h0);
         if (i > 0) chk(mem_addr == 32'h0, "rst_miss_addr", mem_addr, 32'h0);
      end
      @(posedge clk);
      #1;
      rst_in      = 1'b1;
      fetch_valid = 1'b0;
      for (int i = 0; i < LINES; i++) mdl_valid[i] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] pc;
      for (int i = 0; i < LINES; i++) begin
         mdl_valid[i] = 1'b0;
         mdl_addr[i]  = '0;
      end
      @(posedge clk);
      #1;
      fetch_valid = 1'b1;
      fetch_pc    = 32'h0000_0104;
      reset_pulse(3);

      // Cold miss, hit, conflict, re-miss.
      do_fetch(32'h0000_0104, 5, 0);
      do_fetch(32'h0000_0104, 5, 0);
      do_fetch(32'h0000_0144, 3, 0);
      do_fetch(32'h0000_0104, 2, 0);
      do_fetch(32'h0000_0104, 2, 0);

      // Flush on the refill cycle, then stall across a refill.
      do_fetch(32'h0000_0200, 3, 1);
      do_fetch(32'h0000_0200, 3, 0);
      do_fetch(32'h0000_0300, 4, 2);
      do_fetch(32'h0000_0300, 4, 0);

      // Reset after four fills invalidates them all.
      do_fetch(32'h0000_0400, 2, 0);
      do_fetch(32'h0000_0408, 2, 0);
      do_fetch(32'h0000_0410, 2, 0);
      do_fetch(32'h0000_0418, 2, 0);
      fetch_valid = 1'b1;
      fetch_pc    = 32'h0000_0400;
      reset_pulse(2);
      do_fetch(32'h0000_0400, 2, 0);
      do_fetch(32'h0000_0408, 2, 0);
      do_fetch(32'h0000_0410, 2, 0);
      do_fetch(32'h0000_0418, 2, 0);

      for (int n = 0; n < 80; n++) begin
         pc = {($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00, 16'h0,
               2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         do_fetch(pc, $urandom_range(1, 6), 0);
      end

      repeat (4) @(negedge clk);
      chk(exp_q.size() == 0, "exp_q_drained", exp_q.size(), 32'h0);
      chk(mem_q.size() == 0, "mem_q_drained", mem_q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
